pb_field_split: RTL

//  Upstream of the output-merge FSM. Parses a serialized protobuf byte stream
//  one byte per cycle. Writes varint field bytes into the varint data FIFO and

---
 rtl/pb_field_split.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/pb_field_split.sv
// pb_field_split: splits a serialized protobuf stream into varint bytes and
// raw (length-delimited / fixed) payload bytes, one byte per cycle. Each field
// gets a 10-bit index that is pushed to the matching index FIFO. A
// valid/accepted handshake with the downstream merge FSM closes the field.
module pb_field_split #(
  parameter int MAX_VARINT_BYTES = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  input  logic       varint_fifo_full,
  output logic       varint_fifo_push,
  input  logic       raw_fifo_full,
  output logic       raw_fifo_push,
  output logic [7:0] fifo_wdata,
  output logic       varint_index_push,
  output logic       raw_index_push,
  output logic [9:0] field_index,
  output logic       varint_data_valid,
  output logic       raw_data_valid,
  input  logic       varint_data_accepted,
  input  logic       raw_data_accepted,
  output logic       parse_err
);

  localparam int VCNT_W = $clog2(MAX_VARINT_BYTES + 1);

  typedef enum logic [5:0] {
    S_TAG    = 6'b000001,
    S_LEN    = 6'b000010,
    S_VARINT = 6'b000100,
    S_RAW    = 6'b001000,
    S_V_DONE = 6'b010000,
    S_R_DONE = 6'b100000
  } state_t;

  state_t            state_reg, state_next;
  logic [9:0]        field_index_reg, field_index_next;
  logic [7:0]        remain_reg, remain_next;
  logic [VCNT_W-1:0] vcnt_reg, vcnt_next;
  logic [VCNT_W-1:0] vcnt_inc;
  logic              parse_err_reg, parse_err_next;
  logic              last_seen_reg, last_seen_next;
  // High during the first cycle of a DONE state; drives the one-shot index push.
  logic              done_entry_reg, done_entry_next;
  logic              accept;
  logic              varint_at_limit;

  assign accept          = in_valid & in_ready;
  assign vcnt_inc        = vcnt_reg + VCNT_W'(1);
  assign varint_at_limit = (vcnt_inc == VCNT_W'(MAX_VARINT_BYTES));

  // Byte acceptance: only data states look at the FIFO full flags.
  always_comb begin
    in_ready = 1'b0;
    case (state_reg)
      S_TAG, S_LEN: in_ready = 1'b1;
      S_VARINT:     in_ready = !varint_fifo_full;
      S_RAW:        in_ready = !raw_fifo_full;
      default:      in_ready = 1'b0;
    endcase
  end

  // Next-state, field bookkeeping and same-cycle data pushes.
  always_comb begin
    state_next       = state_reg;
    field_index_next = field_index_reg;
    remain_next      = remain_reg;
    vcnt_next        = vcnt_reg;
    parse_err_next   = parse_err_reg;
    last_seen_next   = last_seen_reg;
    done_entry_next  = 1'b0;
    varint_fifo_push = 1'b0;
    raw_fifo_push    = 1'b0;

    case (state_reg)
      S_TAG: begin
        if (accept) begin
          last_seen_next = last_seen_reg | in_last;
          case (in_data[2:0])
            3'd0: begin
              state_next = S_VARINT;
              vcnt_next  = '0;
            end
            3'd2: state_next = S_LEN;
            3'd1: begin
              state_next  = S_RAW;
              remain_next = 8'd8;
            end
            3'd5: begin
              state_next  = S_RAW;
              remain_next = 8'd4;
            end
            default: begin
              // Unsupported wire type: byte is dropped, the field never opens.
              parse_err_next = 1'b1;
              if (in_last) begin
                field_index_next = '0;
                last_seen_next   = 1'b0;
              end
            end
          endcase
        end
      end

      S_LEN: begin
        if (accept) begin
          last_seen_next = last_seen_reg | in_last;
          // Only single-byte lengths are supported; a continuation bit is an
          // error and the low seven bits are used as the length anyway.
          if (in_data[7]) parse_err_next = 1'b1;
          if (in_data[6:0] == 7'd0) begin
            state_next      = S_R_DONE;
            done_entry_next = 1'b1;
          end else begin
            state_next  = S_RAW;
            remain_next = {1'b0, in_data[6:0]};
          end
        end
      end

      S_VARINT: begin
        if (accept) begin
          varint_fifo_push = 1'b1;
          vcnt_next        = vcnt_inc;
          last_seen_next   = last_seen_reg | in_last;
          if (!in_data[7] || varint_at_limit) begin
            state_next      = S_V_DONE;
            done_entry_next = 1'b1;
          end
          if (in_data[7] && varint_at_limit) parse_err_next = 1'b1;
        end
      end

      S_RAW: begin
        if (accept) begin
          raw_fifo_push  = 1'b1;
          remain_next    = remain_reg - 8'd1;
          last_seen_next = last_seen_reg | in_last;
          if (remain_reg == 8'd1) begin
            state_next      = S_R_DONE;
            done_entry_next = 1'b1;
          end
        end
      end

      S_V_DONE, S_R_DONE: begin
        if ((state_reg == S_V_DONE && varint_data_accepted) ||
            (state_reg == S_R_DONE && raw_data_accepted)) begin
          state_next = S_TAG;
          vcnt_next  = '0;
          // The end of a message restarts numbering for the next one.
          if (last_seen_reg) begin
            field_index_next = '0;
            last_seen_next   = 1'b0;
          end else begin
            field_index_next = field_index_reg + 10'd1;
          end
        end
      end

      default: state_next = S_TAG;
    endcase
  end

  // State and field registers; reset abandons any field in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= S_TAG;
      field_index_reg <= '0;
      remain_reg      <= '0;
      vcnt_reg        <= '0;
      parse_err_reg   <= 1'b0;
      last_seen_reg   <= 1'b0;
      done_entry_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      field_index_reg <= field_index_next;
      remain_reg      <= remain_next;
      vcnt_reg        <= vcnt_next;
      parse_err_reg   <= parse_err_next;
      last_seen_reg   <= last_seen_next;
      done_entry_reg  <= done_entry_next;
    end
  end

  assign fifo_wdata        = in_data;
  assign field_index       = field_index_reg;
  assign parse_err         = parse_err_reg;
  assign varint_data_valid = (state_reg == S_V_DONE);
  assign raw_data_valid    = (state_reg == S_R_DONE);
  assign varint_index_push = varint_data_valid & done_entry_reg;
  assign raw_index_push    = raw_data_valid & done_entry_reg;

endmodule
